// File: rtl/dram_arbiter_if.sv
// Core-side and RAM-side signal bundle for the shared data RAM arbiter.
// The master modport is the arbiter; the slave modport is the cores plus RAM.
interface dram_arbiter_if #(
  parameter int WIDTH  = 8,
  parameter int NCORES = 4
);
  logic [NCORES-1:0]       core_read;
  logic [NCORES-1:0]       core_write;
  logic [NCORES*WIDTH-1:0] core_addr;
  logic [NCORES*WIDTH-1:0] core_wdata;
  logic [WIDTH-1:0]        core_rdata;
  logic [NCORES-1:0]       core_ack;
  logic [NCORES-1:0]       core_grant;
  logic [WIDTH-1:0]        mem_addr;
  logic [WIDTH-1:0]        mem_wdata;
  logic [WIDTH-1:0]        mem_rdata;
  logic                    mem_re;
  logic                    mem_we;
  logic                    busy;

  modport master (
    input  core_read, core_write, core_addr,
    input  core_wdata, mem_rdata,
    output core_rdata, core_ack, core_grant,
    output mem_addr, mem_wdata, mem_re, mem_we,
    output busy
  );

  modport slave (
    output core_read, core_write, core_addr,
    output core_wdata, mem_rdata,
    input  core_rdata, core_ack, core_grant,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    input  busy
  );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter serialising NCORES cores onto one RAM port.
// One transaction per three cycles: IDLE arbitrates, ISSUE strobes, RESP acks.
module dram_arbiter #(
  parameter int WIDTH  = 8,
  parameter int NCORES = 4
) (
  input  logic          Clk,
  input  logic          Rst_n,
  dram_arbiter_if.master bus
);
  localparam int IW  = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int IW1 = IW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [NCORES-1:0] gnt_q, gnt_d;
  logic [NCORES-1:0] ack_q, ack_d;
  logic              rd_q, rd_d;
  logic [WIDTH-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;

  logic [NCORES-1:0] req;
  logic              found;
  logic [IW-1:0]     pick;
  logic [IW:0]       idx;
  logic              wr_sel;

  // A core in its ack cycle is masked so it cannot win twice in a row
  always_comb begin
    req   = (bus.core_read | bus.core_write) & ~ack_q;
    found = 1'b0;
    pick  = last_q;
    idx   = '0;
    for (int k = 1; k <= NCORES; k++) begin
      idx = IW1'(last_q) + IW1'(k);
      if (idx >= IW1'(NCORES)) idx = idx - IW1'(NCORES);
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    re_d    = re_q;
    we_d    = we_q;
    wr_sel  = bus.core_write[pick];
    unique case (state_q)
      IDLE: begin
        if (found) begin
          addr_d  = bus.core_addr[pick*WIDTH +: WIDTH];
          wdata_d = bus.core_wdata[pick*WIDTH +: WIDTH];
          we_d    = wr_sel;
          re_d    = !wr_sel;
          rd_d    = !wr_sel;
          gnt_d   = NCORES'(1) << pick;
          last_d  = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        re_d    = 1'b0;
        we_d    = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (rd_q) rdata_d = bus.mem_rdata;
        ack_d   = gnt_q;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      last_q  <= IW'(NCORES - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      re_q    <= re_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.core_rdata = rdata_q;
  assign bus.core_ack   = ack_q;
  assign bus.core_grant = gnt_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_re     = re_q;
  assign bus.mem_we     = we_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: directed core traffic against a RAM model.
// Strobe and ack monitors pop expected entries pushed by the stimulus.
module tb_dram_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  dram_arbiter_if #(.WIDTH(W), .NCORES(N)) bus ();

  dram_arbiter #(.WIDTH(W), .NCORES(N)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  logic [7:0] ram [256];

  always @(posedge Clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
  end

  typedef struct {
    logic       re;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [3:0] gnt;
  } strb_t;

  typedef struct {
    logic [3:0] ack;
    logic       rd;
    logic [7:0] data;
  } ack_t;

  strb_t sq[$];
  ack_t  aq[$];
  int checks = 0;
  int errors = 0;
  int n, n0, n1, n2, n3, n4, na, nb;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_s(bit re, bit we, logic [7:0] a,
                        logic [7:0] d, logic [3:0] g);
    strb_t e;
    e.re = re; e.we = we; e.addr = a; e.wdata = d; e.gnt = g;
    sq.push_back(e);
  endtask

  task automatic push_a(logic [3:0] ack, bit rd, logic [7:0] d);
    ack_t e;
    e.ack = ack; e.rd = rd; e.data = d;
    aq.push_back(e);
  endtask

  logic prev_s = 1'b0;
  always @(negedge Clk) begin
    strb_t e;
    if (bus.mem_re || bus.mem_we) begin
      chk("strobe_one_cycle", 32'(prev_s), 0);
      if (sq.size() == 0) begin
        chk("strobe_unexpected", 1, 0);
      end else begin
        e = sq.pop_front();
        chk("strobe_re", 32'(bus.mem_re), 32'(e.re));
        chk("strobe_we", 32'(bus.mem_we), 32'(e.we));
        chk("strobe_addr", 32'(bus.mem_addr), 32'(e.addr));
        chk("strobe_grant", 32'(bus.core_grant), 32'(e.gnt));
        chk("strobe_busy", 32'(bus.busy), 1);
        if (e.we) chk("strobe_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
      end
    end
    prev_s = bus.mem_re | bus.mem_we;
  end

  always @(negedge Clk) begin
    ack_t e;
    if (bus.core_ack != '0) begin
      if (aq.size() == 0) begin
        chk("ack_unexpected", 32'(bus.core_ack), 0);
      end else begin
        e = aq.pop_front();
        chk("ack_onehot", 32'(bus.core_ack), 32'(e.ack));
        chk("ack_grant_clear", 32'(bus.core_grant), 0);
        if (e.rd) chk("ack_rdata", 32'(bus.core_rdata), 32'(e.data));
      end
    end
  end

  task automatic drive(int i, bit rd, bit wr, logic [7:0] a, logic [7:0] d);
    bus.core_read[i]         = rd;
    bus.core_write[i]        = wr;
    bus.core_addr[i*8 +: 8]  = a;
    bus.core_wdata[i*8 +: 8] = d;
  endtask

  task automatic wait_ack(int i, output int cnt);
    cnt = 0;
    do begin
      @(negedge Clk);
      cnt++;
    end while (!bus.core_ack[i] && cnt < 40);
    if (!bus.core_ack[i]) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout core=%0d actual=none required=ack", i);
    end
  endtask

  task automatic core_op(int i, bit rd, bit wr, logic [7:0] a,
                         logic [7:0] d, output int cnt);
    drive(i, rd, wr, a, d);
    wait_ack(i, cnt);
    bus.core_read[i]  = 1'b0;
    bus.core_write[i] = 1'b0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_ack"}, 32'(bus.core_ack), 0);
    chk({tag, "_grant"}, 32'(bus.core_grant), 0);
    chk({tag, "_re"}, 32'(bus.mem_re), 0);
    chk({tag, "_we"}, 32'(bus.mem_we), 0);
    chk({tag, "_rdata"}, 32'(bus.core_rdata), 0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_wdata"}, 32'(bus.mem_wdata), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bus.core_read  = '0;
    bus.core_write = '0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    ram[8'h10] = 8'hA5;
    ram[8'h20] = 8'h11;
    ram[8'h21] = 8'h22;
    ram[8'h22] = 8'h33;
    ram[8'h23] = 8'h44;
    ram[8'h24] = 8'h55;
    ram[8'h30] = 8'h66;
    ram[8'h31] = 8'h77;
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    chk_all_zero("reset");
    Rst_n = 1'b1;
    @(negedge Clk);

    // single read
    push_s(1, 0, 8'h10, 8'h00, 4'b0001);
    push_a(4'b0001, 1, 8'hA5);
    core_op(0, 1, 0, 8'h10, 8'h00, n);
    chk("single_latency", n, 3);

    // contention from reset, then core 0 wraps after core 3
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    push_s(1, 0, 8'h20, 8'h00, 4'b0001);
    push_s(1, 0, 8'h21, 8'h00, 4'b0010);
    push_s(1, 0, 8'h22, 8'h00, 4'b0100);
    push_s(1, 0, 8'h23, 8'h00, 4'b1000);
    push_s(1, 0, 8'h24, 8'h00, 4'b0001);
    push_a(4'b0001, 1, 8'h11);
    push_a(4'b0010, 1, 8'h22);
    push_a(4'b0100, 1, 8'h33);
    push_a(4'b1000, 1, 8'h44);
    push_a(4'b0001, 1, 8'h55);
    fork
      begin
        core_op(0, 1, 0, 8'h20, 8'h00, n0);
        @(negedge Clk);
        core_op(0, 1, 0, 8'h24, 8'h00, n4);
      end
      core_op(1, 1, 0, 8'h21, 8'h00, n1);
      core_op(2, 1, 0, 8'h22, 8'h00, n2);
      core_op(3, 1, 0, 8'h23, 8'h00, n3);
    join
    chk("cont_lat_c0", n0, 3);
    chk("cont_lat_c1", n1, 6);
    chk("cont_lat_c2", n2, 9);
    chk("cont_lat_c3", n3, 12);
    chk("cont_lat_wrap", n4, 11);

    // write then read-back
    push_s(0, 1, 8'h7F, 8'h3C, 4'b0100);
    push_a(4'b0100, 0, 8'h00);
    core_op(2, 0, 1, 8'h7F, 8'h3C, n);
    chk("write_latency", n, 3);
    push_s(1, 0, 8'h7F, 8'h00, 4'b0010);
    push_a(4'b0010, 1, 8'h3C);
    core_op(1, 1, 0, 8'h7F, 8'h00, n);
    chk("readback_latency", n, 3);

    // read and write together: write first, held read after
    push_s(0, 1, 8'h05, 8'h99, 4'b1000);
    push_s(1, 0, 8'h05, 8'h99, 4'b1000);
    push_a(4'b1000, 0, 8'h00);
    push_a(4'b1000, 1, 8'h99);
    drive(3, 1, 1, 8'h05, 8'h99);
    wait_ack(3, n);
    chk("rw_write_latency", n, 3);
    bus.core_write[3] = 1'b0;
    wait_ack(3, n);
    chk("rw_read_latency", n, 4);
    bus.core_read[3] = 1'b0;

    // fairness between cores 1 and 2
    push_s(1, 0, 8'h30, 8'h00, 4'b0010);
    push_s(1, 0, 8'h31, 8'h00, 4'b0100);
    push_s(1, 0, 8'h30, 8'h00, 4'b0010);
    push_s(1, 0, 8'h31, 8'h00, 4'b0100);
    push_a(4'b0010, 1, 8'h66);
    push_a(4'b0100, 1, 8'h77);
    push_a(4'b0010, 1, 8'h66);
    push_a(4'b0100, 1, 8'h77);
    fork
      begin
        core_op(1, 1, 0, 8'h30, 8'h00, n1);
        @(negedge Clk);
        core_op(1, 1, 0, 8'h30, 8'h00, n3);
      end
      begin
        core_op(2, 1, 0, 8'h31, 8'h00, n2);
        @(negedge Clk);
        core_op(2, 1, 0, 8'h31, 8'h00, n4);
      end
    join
    chk("fair_lat_c1a", n1, 3);
    chk("fair_lat_c2a", n2, 6);
    chk("fair_lat_c1b", n3, 5);
    chk("fair_lat_c2b", n4, 5);

    // reset during ISSUE of a core 0 read
    push_s(1, 0, 8'h10, 8'h00, 4'b0001);
    drive(0, 1, 0, 8'h10, 8'h00);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!bus.mem_re && n < 20);
    chk("midrst_issue_seen", 32'(bus.mem_re), 1);
    Rst_n = 1'b0;
    drive(1, 1, 0, 8'h20, 8'h00);
    @(negedge Clk);
    chk_all_zero("midrst");
    push_s(1, 0, 8'h10, 8'h00, 4'b0001);
    push_s(1, 0, 8'h20, 8'h00, 4'b0010);
    push_a(4'b0001, 1, 8'hA5);
    push_a(4'b0010, 1, 8'h11);
    Rst_n = 1'b1;
    fork
      begin
        wait_ack(0, na);
        bus.core_read[0] = 1'b0;
      end
      begin
        wait_ack(1, nb);
        bus.core_read[1] = 1'b0;
      end
    join
    chk("midrst_c0_first", na, 3);
    chk("midrst_c1_next", nb, 6);

    n = 0;
    while ((sq.size() != 0 || aq.size() != 0) && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("strobe_queue_empty", sq.size(), 0);
    chk("ack_queue_empty", aq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
